// File: rtl/reg_file_p.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass, optional hard-wired zero register, sequential clear sweep.

module reg_file_p_rd #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               ready,
  input  logic                               byp_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  data
);
  always_comb begin
    data = '0;
    if (!ready)                              data = '0;
    else if ((ZERO_R0 != 0) && addr == '0)   data = '0;
    else if (byp_en && wr_addr == addr)      data = wr_data;
    else                                     data = regs[addr];
  end
endmodule

module reg_file_p #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDR,
  input  logic              WRITEEN,
  input  logic [ADDR_W-1:0] OUT1ADD,
  input  logic [ADDR_W-1:0] OUT2ADD,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR_REQ,
  output logic              READY,
  output logic              WRITE_DROP
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NPORTS = 2;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic                           drop_q, drop_d;
  logic                           ready, wr_zero, wr_commit;

  logic [NPORTS-1:0][ADDR_W-1:0]  rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0]  rd_data;

  assign ready     = (state_q == RUN);
  assign wr_zero   = (ZERO_R0 != 0) && (INADDR == '0);
  // A write lands only in RUN with no reset this cycle; CLEAR_REQ does not block it.
  assign wr_commit = ready && WRITEEN && !RESET && !wr_zero;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    drop_d  = 1'b0;
    if (RESET) begin
      state_d = CLEAR;
      ptr_d   = '0;
      drop_d  = WRITEEN;
    end else if (state_q == CLEAR) begin
      regs_d[ptr_q] = '0;
      ptr_d         = ptr_q + 1'b1;
      drop_d        = WRITEEN;
      if (&ptr_q) state_d = RUN;
    end else begin
      if (wr_commit) regs_d[INADDR] = IN;
      if (CLEAR_REQ) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    end
  end

  // Reset is folded into the next-state logic, so every flop here is plain.
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    regs_q  <= regs_d;
    drop_q  <= drop_d;
  end

  assign rd_addr = {OUT2ADD, OUT1ADD};

  for (genvar g = 0; g < NPORTS; g++) begin : g_rd
    reg_file_p_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_rd (
      .regs    (regs_q),
      .addr    (rd_addr[g]),
      .ready   (ready),
      .byp_en  ((BYPASS != 0) && wr_commit),
      .wr_addr (INADDR),
      .wr_data (IN),
      .data    (rd_data[g])
    );
  end

  assign OUT1       = rd_data[0];
  assign OUT2       = rd_data[1];
  assign READY      = ready;
  assign WRITE_DROP = drop_q;
endmodule

// File: tb/tb_reg_file_p.sv
// Bench for reg_file_p: four configurations share one stimulus stream and are
// compared against an array-based model, plus directed vectors and corner sequences.

module tb_reg_file_p;
  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, we, creq;
  logic [31:0] din;
  logic [4:0]  ia, a1, a2;

  logic [7:0]  o1_0, o2_0, o1_1, o2_1, o1_2, o2_2;
  logic [31:0] o1_3, o2_3;
  logic [3:0]  rdy, drp;

  int checks = 0;
  int errors = 0;

  reg_file_p #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u0 (
    .CLK(CLK), .RESET(rst), .IN(din[7:0]), .INADDR(ia[2:0]), .WRITEEN(we),
    .OUT1ADD(a1[2:0]), .OUT2ADD(a2[2:0]), .OUT1(o1_0), .OUT2(o2_0),
    .CLEAR_REQ(creq), .READY(rdy[0]), .WRITE_DROP(drp[0]));
  reg_file_p #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) u1 (
    .CLK(CLK), .RESET(rst), .IN(din[7:0]), .INADDR(ia[2:0]), .WRITEEN(we),
    .OUT1ADD(a1[2:0]), .OUT2ADD(a2[2:0]), .OUT1(o1_1), .OUT2(o2_1),
    .CLEAR_REQ(creq), .READY(rdy[1]), .WRITE_DROP(drp[1]));
  reg_file_p #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) u2 (
    .CLK(CLK), .RESET(rst), .IN(din[7:0]), .INADDR(ia[2:0]), .WRITEEN(we),
    .OUT1ADD(a1[2:0]), .OUT2ADD(a2[2:0]), .OUT1(o1_2), .OUT2(o2_2),
    .CLEAR_REQ(creq), .READY(rdy[2]), .WRITE_DROP(drp[2]));
  reg_file_p #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_R0(0)) u3 (
    .CLK(CLK), .RESET(rst), .IN(din), .INADDR(ia), .WRITEEN(we),
    .OUT1ADD(a1), .OUT2ADD(a2), .OUT1(o1_3), .OUT2(o2_3),
    .CLEAR_REQ(creq), .READY(rdy[3]), .WRITE_DROP(drp[3]));

  int cdw  [4] = '{8, 8, 8, 32};
  int caw  [4] = '{3, 3, 3, 5};
  int cbyp [4] = '{1, 0, 1, 1};
  int cz   [4] = '{0, 0, 1, 0};

  // Model: register contents, sweep position, run flag, pending drop pulse.
  logic [31:0] mregs [4][32];
  int          mptr  [4];
  bit          mrun  [4];
  bit          mdrop [4];
  bit          mvalid = 1'b0;

  function automatic logic [31:0] dout(int k, bit second);
    case (k)
      0:       return second ? {24'd0, o2_0} : {24'd0, o1_0};
      1:       return second ? {24'd0, o2_1} : {24'd0, o1_1};
      2:       return second ? {24'd0, o2_2} : {24'd0, o1_2};
      default: return second ? o2_3 : o1_3;
    endcase
  endfunction

  function automatic logic [31:0] dmask(int k);
    return (cdw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cdw[k]) - 32'd1);
  endfunction

  function automatic int am(int k, logic [4:0] a);
    return int'(a) % (1 << caw[k]);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    int ra = am(k, a);
    int wa = am(k, ia);
    if (!mrun[k]) return 32'd0;
    if (cz[k] != 0 && ra == 0) return 32'd0;
    if (cbyp[k] != 0 && we && !rst && wa == ra && !(cz[k] != 0 && wa == 0))
      return din & dmask(k);
    return mregs[k][ra];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int wa = am(k, ia);
      int depth = 1 << caw[k];
      if (rst) begin
        mrun[k] = 1'b0; mptr[k] = 0; mdrop[k] = we;
      end else if (!mrun[k]) begin
        mregs[k][mptr[k]] = 32'd0;
        mdrop[k] = we;
        if (mptr[k] == depth - 1) mrun[k] = 1'b1;
        mptr[k] = (mptr[k] + 1) % depth;
      end else begin
        mdrop[k] = 1'b0;
        if (we && !(cz[k] != 0 && wa == 0)) mregs[k][wa] = din & dmask(k);
        if (creq) begin mrun[k] = 1'b0; mptr[k] = 0; end
      end
    end
    if (rst) mvalid = 1'b1;
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic tick();
    #1;
    if (mvalid)
      for (int k = 0; k < 4; k++) begin
        chk("m_ready", k, {31'd0, rdy[k]}, {31'd0, mrun[k]});
        chk("m_drop",  k, {31'd0, drp[k]}, {31'd0, mdrop[k]});
        chk("m_out1",  k, dout(k, 1'b0), exp_rd(k, a1));
        chk("m_out2",  k, dout(k, 1'b1), exp_rd(k, a2));
      end
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  ia;
    logic [31:0] d;
    logic [4:0]  a1, a2;
    bit          cr;
    bit          rdy;
    logic [7:0]  o1, o2, nb1;
    bit          drop;
  } vec_t;

  vec_t tbl [16];

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 32; r++) mregs[k][r] = 32'd0;
      mptr[k] = 0; mrun[k] = 1'b0; mdrop[k] = 1'b0;
    end
    //           we  ia     d        a1     a2     cr   rdy  o1     o2     nb1    drop
    tbl[0]  = '{1'b1, 5'd3, 32'h5A, 5'd0, 5'd0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 5'd7, 32'hC3, 5'd3, 5'd0, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h5A, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h00, 5'd3, 5'd7, 1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 1'b0};
    tbl[3]  = '{1'b1, 5'd3, 32'h11, 5'd3, 5'd7, 1'b0, 1'b1, 8'h11, 8'hC3, 8'h5A, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h00, 5'd3, 5'd3, 1'b0, 1'b1, 8'h11, 8'h11, 8'h11, 1'b0};
    tbl[5]  = '{1'b1, 5'd2, 32'hAA, 5'd2, 5'd3, 1'b1, 1'b1, 8'hAA, 8'h11, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h00, 5'd2, 5'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 5'd5, 32'hBB, 5'd5, 5'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h00, 5'd5, 5'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{1'b0, 5'd0, 32'h00, 5'd5, 5'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 32'h00, 5'd2, 5'd5, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 5'd0, 32'h00, 5'd3, 5'd7, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};

    rst = 1'b1; we = 1'b0; creq = 1'b0; din = '0; ia = '0; a1 = '0; a2 = '0;
    tick(); tick();
    rst = 1'b0;
    // Sweep lengths: 8 cycles for the narrow files, 32 for the wide one.
    for (int i = 0; i <= 32; i++) begin
      #1;
      chk("rst_ready8",  0, {31'd0, rdy[0]}, {31'd0, (i >= 8)});
      chk("rst_ready32", 3, {31'd0, rdy[3]}, {31'd0, (i >= 32)});
      tick();
    end
    for (int r = 0; r < 8; r++) begin
      a1 = 5'(r); a2 = 5'(7 - r);
      #1;
      chk("swept_out1", 0, dout(0, 1'b0), 32'd0);
      chk("swept_out2", 0, dout(0, 1'b1), 32'd0);
      tick();
    end

    foreach (tbl[i]) begin
      we = tbl[i].we; ia = tbl[i].ia; din = tbl[i].d;
      a1 = tbl[i].a1; a2 = tbl[i].a2; creq = tbl[i].cr;
      #1;
      chk("tbl_ready", 0, {31'd0, rdy[0]}, {31'd0, tbl[i].rdy});
      chk("tbl_out1",  0, dout(0, 1'b0), {24'd0, tbl[i].o1});
      chk("tbl_out2",  0, dout(0, 1'b1), {24'd0, tbl[i].o2});
      chk("tbl_nb1",   1, dout(1, 1'b0), {24'd0, tbl[i].nb1});
      chk("tbl_drop",  0, {31'd0, drp[0]}, {31'd0, tbl[i].drop});
      tick();
    end
    we = 1'b0; creq = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    #1 chk("wide_ready", 3, {31'd0, rdy[3]}, 32'd1);

    we = 1'b1; ia = 5'd31; din = 32'hDEAD_BEEF; a1 = 5'd0; a2 = 5'd0;
    tick();
    we = 1'b0; a1 = 5'd31; a2 = 5'd31;
    #1;
    chk("wide_out1", 3, dout(3, 1'b0), 32'hDEAD_BEEF);
    chk("wide_out2", 3, dout(3, 1'b1), 32'hDEAD_BEEF);
    tick();

    we = 1'b1; ia = 5'd0; din = 32'hFF; a1 = 5'd0; a2 = 5'd0;
    #1;
    chk("zero_out1",  2, dout(2, 1'b0), 32'd0);
    chk("plain_byp0", 0, dout(0, 1'b0), 32'hFF);
    tick();
    we = 1'b0;
    #1;
    chk("zero_out1_after", 2, dout(2, 1'b0), 32'd0);
    chk("zero_nodrop",     2, {31'd0, drp[2]}, 32'd0);
    chk("plain_r0",        0, dout(0, 1'b0), 32'hFF);
    tick();

    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      #1;
      chk("mid_ready8",  0, {31'd0, rdy[0]}, {31'd0, (i >= 8)});
      chk("mid_ready32", 3, {31'd0, rdy[3]}, {31'd0, (i >= 32)});
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      creq = ($urandom_range(0, 24) == 0);
      we   = $urandom_range(0, 1) == 1;
      din  = $urandom;
      ia   = 5'($urandom_range(0, 31));
      a1   = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
      a2   = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
